// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer and its CSR neighbours.
package trap_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_ENTER  = 3'd2,
    ST_RETURN = 3'd3,
    ST_SLEEP  = 3'd4
  } trap_state_e;

  localparam logic [31:0] MTVEC_DEFAULT = 32'h1000_0000;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;

  localparam logic [1:0] MPP_M = 2'b11;

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: drives hardware CSR updates, PC redirect and flush
// for interrupt entry, MRET return and WFI sleep/wake.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] MTVEC   = DATA_W'(MTVEC_DEFAULT),
  parameter int                PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              interrupt,
  input  logic              mstatus_mie,
  input  logic              mstatus_mpie,
  input  logic              mie_meie,
  input  logic [DATA_W-1:0] mepc_in,
  input  logic              exe_valid,
  input  logic [DATA_W-1:0] exe_pc,
  input  logic              exe_mret,
  input  logic              exe_wfi,
  input  logic              Istall,
  input  logic              Dstall,
  output logic              hw_mepc_we,
  output logic [DATA_W-1:0] hw_mepc,
  output logic              hw_mstatus_we,
  output logic              hw_mstatus_mie,
  output logic              hw_mstatus_mpie,
  output logic [1:0]        hw_mstatus_mpp,
  output logic              csr_wr_block,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              flush,
  output logic              stall_req,
  output logic [2:0]        state_dbg
);

  trap_state_e       r_state;
  logic [DATA_W-1:0] r_saved_pc;
  logic              r_resume;

  logic w_stall;
  logic w_pend;
  logic w_wake;

  assign w_stall = Istall | Dstall;
  assign w_pend  = interrupt & mstatus_mie & mie_meie;
  assign w_wake  = interrupt & mie_meie;

  // r_resume marks the single RUN cycle that re-fetches after a WFI woken without a trap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_saved_pc <= '0;
      r_resume   <= 1'b0;
    end else begin
      r_resume <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_pend && exe_valid && !w_stall) begin
            r_saved_pc <= exe_pc;
            r_state    <= ST_ENTER;
          end else if (w_pend && exe_valid) begin
            r_saved_pc <= exe_pc;
            r_state    <= ST_DRAIN;
          end else if (exe_mret && exe_valid && !w_stall) begin
            r_state <= ST_RETURN;
          end else if (exe_wfi && exe_valid && !w_stall) begin
            r_saved_pc <= exe_pc + DATA_W'(PC_STEP);
            r_state    <= ST_SLEEP;
          end
        end
        ST_DRAIN: begin
          if (!w_stall) r_state <= w_pend ? ST_ENTER : ST_RUN;
        end
        ST_ENTER:  r_state <= ST_RUN;
        ST_RETURN: r_state <= ST_RUN;
        ST_SLEEP: begin
          if (w_wake && w_pend) begin
            r_state <= ST_ENTER;
          end else if (w_wake) begin
            r_state  <= ST_RUN;
            r_resume <= 1'b1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    hw_mepc_we      = 1'b0;
    hw_mepc         = '0;
    hw_mstatus_we   = 1'b0;
    hw_mstatus_mie  = 1'b0;
    hw_mstatus_mpie = 1'b0;
    hw_mstatus_mpp  = 2'b00;
    csr_wr_block    = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    flush           = 1'b0;
    stall_req       = 1'b0;
    case (r_state)
      ST_ENTER: begin
        hw_mepc_we      = 1'b1;
        hw_mepc         = r_saved_pc;
        hw_mstatus_we   = 1'b1;
        hw_mstatus_mie  = 1'b0;
        hw_mstatus_mpie = mstatus_mie;
        hw_mstatus_mpp  = MPP_M;
        csr_wr_block    = 1'b1;
        redirect_valid  = 1'b1;
        redirect_pc     = MTVEC;
        flush           = 1'b1;
      end
      ST_RETURN: begin
        hw_mstatus_we   = 1'b1;
        hw_mstatus_mie  = mstatus_mpie;
        hw_mstatus_mpie = 1'b1;
        hw_mstatus_mpp  = MPP_M;
        csr_wr_block    = 1'b1;
        redirect_valid  = 1'b1;
        redirect_pc     = mepc_in;
        flush           = 1'b1;
      end
      ST_SLEEP: stall_req = 1'b1;
      ST_RUN: begin
        if (r_resume) begin
          redirect_valid = 1'b1;
          redirect_pc    = r_saved_pc;
          flush          = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign state_dbg = r_state;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios pinned with literals, then
// randomized traffic compared every cycle against a behavioural model.
module tb_trap_ctrl;

  localparam logic [31:0] TB_MTVEC = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        interrupt, mstatus_mie, mstatus_mpie, mie_meie;
  logic [31:0] mepc_in;
  logic        exe_valid;
  logic [31:0] exe_pc;
  logic        exe_mret, exe_wfi, Istall, Dstall;
  logic        hw_mepc_we;
  logic [31:0] hw_mepc;
  logic        hw_mstatus_we, hw_mstatus_mie, hw_mstatus_mpie;
  logic [1:0]  hw_mstatus_mpp;
  logic        csr_wr_block, redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush, stall_req;
  logic [2:0]  state_dbg;

  int checkCount = 0;
  int errorCount = 0;

  // Model: mode is the spec state number, mSaved the trap PC, mResume the WFI re-fetch cycle.
  int          mMode, mModeNext;
  logic [31:0] mSaved, mSavedNext;
  bit          mResume, mResumeNext;

  trap_ctrl dut (
    .clk(clk), .rst(rst), .interrupt(interrupt), .mstatus_mie(mstatus_mie),
    .mstatus_mpie(mstatus_mpie), .mie_meie(mie_meie), .mepc_in(mepc_in),
    .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_mret(exe_mret), .exe_wfi(exe_wfi),
    .Istall(Istall), .Dstall(Dstall), .hw_mepc_we(hw_mepc_we), .hw_mepc(hw_mepc),
    .hw_mstatus_we(hw_mstatus_we), .hw_mstatus_mie(hw_mstatus_mie),
    .hw_mstatus_mpie(hw_mstatus_mpie), .hw_mstatus_mpp(hw_mstatus_mpp),
    .csr_wr_block(csr_wr_block), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .stall_req(stall_req), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Next model state from the current inputs, following the trap rules directly.
  task automatic modelNext();
    bit stall, pend, wake;
    stall = Istall | Dstall;
    pend  = interrupt & mstatus_mie & mie_meie;
    wake  = interrupt & mie_meie;
    mModeNext = mMode; mSavedNext = mSaved; mResumeNext = 0;
    if (rst) begin
      mModeNext = 0; mSavedNext = 0;
    end else if (mMode == 0) begin
      if (pend && exe_valid) begin
        mSavedNext = exe_pc;
        mModeNext  = stall ? 1 : 2;
      end else if (exe_mret && exe_valid && !stall) mModeNext = 3;
      else if (exe_wfi && exe_valid && !stall) begin
        mSavedNext = exe_pc + 32'd4;
        mModeNext  = 4;
      end
    end else if (mMode == 1) begin
      if (!stall) mModeNext = pend ? 2 : 0;
    end else if (mMode == 2 || mMode == 3) begin
      mModeNext = 0;
    end else if (wake) begin
      mModeNext   = pend ? 2 : 0;
      mResumeNext = !pend;
    end
  endtask

  task automatic compareAll();
    bit enter, ret;
    enter = (mMode == 2);
    ret   = (mMode == 3);
    checkOutput("state_dbg", 32'(state_dbg), 32'(mMode));
    checkOutput("hw_mepc_we", 32'(hw_mepc_we), 32'(enter));
    checkOutput("hw_mepc", hw_mepc, enter ? mSaved : 32'h0);
    checkOutput("hw_mstatus_we", 32'(hw_mstatus_we), 32'(enter | ret));
    checkOutput("hw_mstatus_mie", 32'(hw_mstatus_mie), 32'(ret & mstatus_mpie));
    checkOutput("hw_mstatus_mpie", 32'(hw_mstatus_mpie), 32'(ret | (enter & mstatus_mie)));
    checkOutput("hw_mstatus_mpp", 32'(hw_mstatus_mpp), (enter | ret) ? 32'd3 : 32'd0);
    checkOutput("csr_wr_block", 32'(csr_wr_block), 32'(enter | ret));
    checkOutput("redirect_valid", 32'(redirect_valid), 32'(enter | ret | mResume));
    checkOutput("redirect_pc", redirect_pc,
                enter ? TB_MTVEC : ret ? mepc_in : mResume ? mSaved : 32'h0);
    checkOutput("flush", 32'(flush), 32'(enter | ret | mResume));
    checkOutput("stall_req", 32'(stall_req), 32'(mMode == 4));
  endtask

  // Inputs are already driven; clock one edge, then advance the model and compare.
  task automatic applyStimulus();
    modelNext();
    @(negedge clk);
    mMode = mModeNext; mSaved = mSavedNext; mResume = mResumeNext;
    compareAll();
  endtask

  task automatic clearInputs();
    interrupt = 0; mstatus_mie = 0; mstatus_mpie = 0; mie_meie = 0; mepc_in = 0;
    exe_valid = 0; exe_pc = 0; exe_mret = 0; exe_wfi = 0; Istall = 0; Dstall = 0;
  endtask

  initial begin
    rst = 1; clearInputs();
    mMode = 0; mSaved = 0; mResume = 0;
    @(negedge clk);
    compareAll();
    checkOutput("reset redirect_valid", 32'(redirect_valid), 32'd0);
    applyStimulus();
    rst = 0;
    applyStimulus();

    // Trap entry with a clean pipeline.
    mstatus_mie = 1; mie_meie = 1; exe_valid = 1; exe_pc = 32'h100; interrupt = 1;
    applyStimulus();
    checkOutput("entry state", 32'(state_dbg), 32'd2);
    checkOutput("entry mepc", hw_mepc, 32'h100);
    checkOutput("entry mpie", 32'(hw_mstatus_mpie), 32'd1);
    checkOutput("entry mie", 32'(hw_mstatus_mie), 32'd0);
    checkOutput("entry redirect_pc", redirect_pc, 32'h1000_0000);
    checkOutput("entry flush", 32'(flush), 32'd1);
    interrupt = 0;
    applyStimulus();
    checkOutput("after entry state", 32'(state_dbg), 32'd0);

    // Drain while Dstall is high for three cycles.
    interrupt = 1; Dstall = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("drain state", 32'(state_dbg), 32'd1);
      checkOutput("drain redirect", 32'(redirect_valid), 32'd0);
    end
    Dstall = 0;
    applyStimulus();
    checkOutput("drain enter mepc", hw_mepc, 32'h100);
    interrupt = 0;
    applyStimulus();

    // Interrupt withdrawn during drain.
    interrupt = 1; Dstall = 1;
    applyStimulus();
    interrupt = 0;
    applyStimulus();
    Dstall = 0;
    applyStimulus();
    checkOutput("drop state", 32'(state_dbg), 32'd0);
    checkOutput("drop mepc_we", 32'(hw_mepc_we), 32'd0);
    applyStimulus();
    checkOutput("drop redirect", 32'(redirect_valid), 32'd0);

    // MRET.
    exe_mret = 1; mepc_in = 32'h204; mstatus_mpie = 1;
    applyStimulus();
    checkOutput("mret state", 32'(state_dbg), 32'd3);
    checkOutput("mret mie", 32'(hw_mstatus_mie), 32'd1);
    checkOutput("mret redirect_pc", redirect_pc, 32'h204);
    exe_mret = 0;
    applyStimulus();

    // WFI woken with MIE clear: resume redirect only.
    mstatus_mie = 0; exe_wfi = 1; exe_pc = 32'h300;
    applyStimulus();
    checkOutput("wfi stall_req", 32'(stall_req), 32'd1);
    exe_wfi = 0; exe_valid = 0;
    applyStimulus();
    checkOutput("sleep hold", 32'(state_dbg), 32'd4);
    interrupt = 1;
    applyStimulus();
    checkOutput("wake redirect_pc", redirect_pc, 32'h304);
    checkOutput("wake state", 32'(state_dbg), 32'd0);
    interrupt = 0;
    applyStimulus();
    checkOutput("wake single", 32'(redirect_valid), 32'd0);

    // WFI woken with MIE set: trap with mepc past the WFI.
    mstatus_mie = 1; exe_valid = 1; exe_wfi = 1;
    applyStimulus();
    exe_wfi = 0; exe_valid = 0; interrupt = 1;
    applyStimulus();
    checkOutput("wfi trap mepc", hw_mepc, 32'h304);
    interrupt = 0;
    applyStimulus();

    // PC wrap on WFI at the top of the address space.
    mstatus_mie = 0; exe_valid = 1; exe_wfi = 1; exe_pc = 32'hFFFF_FFFC;
    applyStimulus();
    exe_wfi = 0; interrupt = 1;
    applyStimulus();
    checkOutput("wrap redirect_pc", redirect_pc, 32'h0);
    interrupt = 0;
    applyStimulus();

    // Interrupt beats a simultaneous MRET.
    mstatus_mie = 1; interrupt = 1; exe_mret = 1; exe_pc = 32'h500;
    applyStimulus();
    checkOutput("prio state", 32'(state_dbg), 32'd2);
    checkOutput("prio mepc", hw_mepc, 32'h500);
    interrupt = 0; exe_mret = 0;
    applyStimulus();

    // Asynchronous reset while sleeping.
    exe_wfi = 1;
    applyStimulus();
    exe_wfi = 0;
    #3 rst = 1;
    #1;
    checkOutput("async rst stall_req", 32'(stall_req), 32'd0);
    checkOutput("async rst state", 32'(state_dbg), 32'd0);
    mMode = 0; mSaved = 0; mResume = 0;
    applyStimulus();
    rst = 0;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      interrupt    = ($urandom_range(0, 9) < 3);
      mstatus_mie  = $urandom_range(0, 1);
      mstatus_mpie = $urandom_range(0, 1);
      mie_meie     = ($urandom_range(0, 9) < 7);
      mepc_in      = $urandom & 32'hFFFF_FFFC;
      exe_valid    = ($urandom_range(0, 9) < 8);
      exe_pc       = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      exe_mret     = ($urandom_range(0, 99) < 15);
      exe_wfi      = ($urandom_range(0, 99) < 10);
      Istall       = ($urandom_range(0, 9) < 2);
      Dstall       = ($urandom_range(0, 9) < 2);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap sequencer for the machine-mode CSR file. Watches the external interrupt line, MRET and WFI in EXE, and the pipeline stall flags. Sequences the hardware-side CSR updates (mepc, mstatus MIE/MPIE/MPP) and issues the PC redirect and flush for trap entry, MRET return and WFI wake-up. Sits between the controller/hazard unit, the CSR block and the PC mux.

Parameters:
DATA_W, 32, data/PC width
MTVEC, 32'h1000_0000, trap vector; matches the hardwired mtvec
PC_STEP, 4, instruction size used for WFI resume

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
interrupt  in  1  external interrupt level from sctrl (already synchronous)
mstatus_mie  in  1  current mstatus[3]
mstatus_mpie  in  1  current mstatus[7]
mie_meie  in  1  current mie[11]
mepc_in  in  DATA_W  current mepc, used as MRET target
exe_valid  in  1  EXE holds a real (non-bubble) instruction
exe_pc  in  DATA_W  PC of the EXE instruction
exe_mret  in  1  EXE instruction is MRET
exe_wfi  in  1  EXE instruction is WFI
Istall  in  1  instruction-side stall
Dstall  in  1  data-side stall
hw_mepc_we  out  1  hardware write strobe for mepc
hw_mepc  out  DATA_W  value to write to mepc
hw_mstatus_we  out  1  hardware write strobe for mstatus MIE/MPIE/MPP
hw_mstatus_mie  out  1  new MIE
hw_mstatus_mpie  out  1  new MPIE
hw_mstatus_mpp  out  2  new MPP
csr_wr_block  out  1  suppresses software CSR writes this cycle
redirect_valid  out  1  PC mux takes redirect_pc
redirect_pc  out  DATA_W  redirect target
flush  out  1  kill IF/ID/EXE contents
stall_req  out  1  freeze the front end (WFI sleep)
state_dbg  out  3  current FSM state encoding

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- stall = Istall | Dstall.
- pend = interrupt & mstatus_mie & mie_meie.
- wake = interrupt & mie_meie. WFI wake-up ignores MIE.
- States: RUN(0), DRAIN(1), ENTER(2), RETURN(3), SLEEP(4). A register saved_pc (DATA_W) holds the trap PC.
- Reset: state=RUN, saved_pc=0. All outputs are 0; redirect_pc=0, hw_mepc=0.
- RUN, in priority order:
  - pend & exe_valid & !stall: saved_pc<=exe_pc; go to ENTER. The EXE instruction does not retire, and the interrupt wins over a simultaneous MRET/WFI.
  - pend & exe_valid & stall: saved_pc<=exe_pc; go to DRAIN.
  - exe_mret & exe_valid & !stall: go to RETURN.
  - exe_wfi & exe_valid & !stall: saved_pc<=exe_pc+PC_STEP; go to SLEEP. A pending interrupt in this cycle is handled by the first rule instead.
  - Otherwise stay in RUN.
  - pend with !exe_valid: stay in RUN and wait for a valid instruction.
- DRAIN: hold while stall.
  - On !stall with pend still true: go to ENTER.
  - On !stall with pend gone: go to RUN with no side effects.
- ENTER (exactly 1 cycle), then RUN:
  - hw_mepc_we=1, hw_mepc=saved_pc.
  - hw_mstatus_we=1, MPIE<=mstatus_mie, MIE<=0, MPP<=2'b11.
  - redirect_valid=1, redirect_pc=MTVEC.
  - flush=1, csr_wr_block=1.
- RETURN (exactly 1 cycle), then RUN:
  - hw_mstatus_we=1, MIE<=mstatus_mpie, MPIE<=1, MPP<=2'b11.
  - redirect_valid=1, redirect_pc=mepc_in.
  - flush=1, csr_wr_block=1.
- SLEEP: stall_req=1 every cycle.
  - On wake & pend: go to ENTER. mepc gets the instruction after the WFI.
  - On wake & !pend: one cycle with redirect_valid=1, redirect_pc=saved_pc, flush=1; then RUN.
  - Otherwise hold in SLEEP.
- Latency: interrupt asserted with a clean pipeline gives redirect_valid exactly 1 cycle later (the ENTER cycle). The PC fetches MTVEC on the following edge.
- Hardware CSR writes are never gated by stall. csr_wr_block guarantees no software write collides with them.
- Reset mid-operation (any state): return immediately to RUN with all outputs 0. No partial CSR write is issued.
- Width rules: PC arithmetic is mod 2^DATA_W, so exe_pc=32'hFFFF_FFFC with WFI saves 0.

Decomposition:
- Package trap_pkg:
  - trap_state_e enum (3-bit) with the encodings above.
  - MTVEC_DEFAULT.
  - CSR address constants: MSTATUS 12'h300, MIE 12'h304, MTVEC 12'h305, MEPC 12'h341.
  - MPP_M = 2'b11.
- A single module with no sub-module. The FSM, saved_pc register and output decode together form one cohesive unit of about 200 lines.

Test Plan:
- Trap entry: MIE=1, MEIE=1, exe_pc=0x100, no stall; raise interrupt. Next cycle ENTER: hw_mepc=0x100, hw_mstatus MIE=0/MPIE=1/MPP=11, redirect_pc=0x1000_0000, flush=1. Following cycle RUN.
- Drain: same setup with Dstall=1 for 3 cycles. state=DRAIN for 3 cycles, no outputs. ENTER on the cycle after Dstall drops, mepc=0x100.
- Drop during drain: interrupt falls during DRAIN. Return to RUN; hw_mepc_we and redirect_valid never assert.
- MRET: exe_mret, mepc_in=0x204, MPIE=1. RETURN cycle: MIE=1, MPIE=1, redirect_pc=0x204, flush=1.
- WFI: exe_wfi at 0x300 with MIE=0, MEIE=1. stall_req=1 while sleeping. Raise interrupt: one redirect to 0x304, then RUN. Repeat with MIE=1: ENTER with hw_mepc=0x304.
- Reset and priority: interrupt and exe_mret in the same cycle go to ENTER with mepc=exe_pc. Asserting rst during SLEEP clears stall_req asynchronously, and state_dbg=0.
